// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer: steps an activation word through up to NUM_LAYERS layer computations.
// Ports: clk_i/rst_ni clock and async active-low reset; new_data_i/data_i/cfg_layers_i start a run;
// wt_req_o/wt_layer_o/wt_ready_i weight fetch handshake; calc_start_o/calc_in_o/calc_done_i/calc_result_i
// layer compute handshake; busy_o/output_ready_o/mlp_output_o/done_o/err_o run status and result.
module mlp_layer_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_LAYERS     = 4,
  parameter int NUMLAYERBITS   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    new_data_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [NUMLAYERBITS-1:0] cfg_layers_i,
  output logic                    wt_req_o,
  output logic [NUMLAYERBITS-1:0] wt_layer_o,
  input  logic                    wt_ready_i,
  output logic                    calc_start_o,
  output logic [DATA_WIDTH-1:0]   calc_in_o,
  input  logic                    calc_done_i,
  input  logic [DATA_WIDTH-1:0]   calc_result_i,
  output logic                    busy_o,
  output logic                    output_ready_o,
  output logic [DATA_WIDTH-1:0]   mlp_output_o,
  output logic                    done_o,
  output logic                    err_o
);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [NUMLAYERBITS-1:0] LMAX = NUMLAYERBITS'(NUM_LAYERS - 1);
  typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, ACT, DONE} state_e;
  state_e state_q;
  logic [NUMLAYERBITS-1:0] cur_q, last_q, cfg_m1, last_d;
  logic [DATA_WIDTH-1:0] act_q, res_q, out_q;
  logic [TW-1:0] cnt_q;
  logic first_q, done_q, err_q, timeout;
  // The run length is stored as the index of the last layer so NUM_LAYERS itself never needs to fit.
  assign cfg_m1  = cfg_layers_i - NUMLAYERBITS'(1);
  assign last_d  = (cfg_layers_i == '0) ? '0 : (cfg_m1 > LMAX) ? LMAX : cfg_m1;
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TLIM);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= '0;
      act_q   <= '0;
      res_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (new_data_i) begin
          act_q   <= data_i;
          last_q  <= last_d;
          cur_q   <= '0;
          cnt_q   <= '0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= LOAD_W;
        end
        LOAD_W: if (wt_ready_i) begin
          cnt_q   <= '0;
          first_q <= 1'b1;
          state_q <= COMPUTE;
        end else if (timeout) begin
          err_q   <= 1'b1;
          state_q <= IDLE;
        end else cnt_q <= cnt_q + TW'(1);
        COMPUTE: begin
          first_q <= 1'b0;
          // a done strobe coinciding with the launch pulse belongs to no computation of ours
          if (!first_q && calc_done_i) begin
            res_q   <= calc_result_i;
            state_q <= ACT;
          end else if (timeout) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else cnt_q <= cnt_q + TW'(1);
        end
        ACT: if (cur_q == last_q) begin
          out_q   <= res_q;
          done_q  <= 1'b1;
          state_q <= DONE;
        end else begin
          act_q   <= res_q[DATA_WIDTH-1] ? '0 : res_q;
          cur_q   <= cur_q + NUMLAYERBITS'(1);
          cnt_q   <= '0;
          state_q <= LOAD_W;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign wt_req_o       = state_q == LOAD_W;
  assign wt_layer_o     = cur_q;
  assign calc_start_o   = (state_q == COMPUTE) && first_q;
  assign calc_in_o      = act_q;
  assign busy_o         = state_q != IDLE;
  assign output_ready_o = state_q == DONE;
  assign mlp_output_o   = out_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// tb_mlp_layer_sequencer: randomized self-checking bench with a layer-level reference model.
module tb_mlp_layer_sequencer;
  logic clk = 1'b0, rst_ni = 1'b0, new_data = 1'b0, wt_ready = 1'b0, calc_done = 1'b0;
  logic [7:0] data = '0, calc_result = '0;
  logic [3:0] cfg = '0;
  logic wt_req, calc_start, busy, output_ready, done, err;
  logic [3:0] wt_layer;
  logic [7:0] calc_in, mlp_output;
  int checks = 0, errors = 0, cyc = 0, n_start = 0, n_ordy = 0;
  bit noise = 0;
  logic [7:0] res [4];
  logic [7:0] exp_out = '0;
  always #5 clk = ~clk;
  mlp_layer_sequencer #(.DATA_WIDTH(8), .NUM_LAYERS(4), .NUMLAYERBITS(4), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .new_data_i(new_data), .data_i(data), .cfg_layers_i(cfg),
    .wt_req_o(wt_req), .wt_layer_o(wt_layer), .wt_ready_i(wt_ready),
    .calc_start_o(calc_start), .calc_in_o(calc_in), .calc_done_i(calc_done), .calc_result_i(calc_result),
    .busy_o(busy), .output_ready_o(output_ready), .mlp_output_o(mlp_output), .done_o(done), .err_o(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (calc_start) n_start++;
    if (output_ready) n_ordy++;
    new_data = noise && ($urandom_range(0, 3) == 0);
  endtask
  function automatic int clampn(input logic [3:0] c);
    return c == 0 ? 1 : (c > 4 ? 4 : int'(c));
  endfunction
  task automatic check_all_zero();
    chk("rst_busy", busy, 0); chk("rst_wt_req", wt_req, 0); chk("rst_wt_layer", wt_layer, 0);
    chk("rst_calc_start", calc_start, 0); chk("rst_calc_in", calc_in, 0);
    chk("rst_ordy", output_ready, 0); chk("rst_out", mlp_output, 0);
    chk("rst_done", done, 0); chk("rst_err", err, 0);
  endtask
  task automatic do_run(input logic [7:0] d, input logic [3:0] c, input bit rnd, input bit glitch);
    int n, t0, s0, o0, wd, cd, lat;
    logic [7:0] ain;
    bit g;
    n = clampn(c); s0 = n_start; o0 = n_ordy; t0 = cyc; lat = 1; ain = d;
    new_data = 1; data = d; cfg = c; noise = rnd;
    step();
    data = 8'($urandom); cfg = 4'($urandom);
    chk("busy_start", busy, 1); chk("done_clr", done, 0); chk("err_clr", err, 0);
    for (int l = 0; l < n; l++) begin
      wd = rnd ? $urandom_range(0, 2) : 0;
      g  = rnd ? 1'($urandom_range(0, 1)) : glitch;
      cd = rnd ? $urandom_range(0, 2) : (glitch ? 2 : 0);
      chk("wt_req", wt_req, 1); chk("wt_layer", wt_layer, l);
      repeat (wd) begin
        step();
        chk("wt_hold", wt_req, 1);
      end
      wt_ready = 1;
      step();
      wt_ready = 0;
      chk("calc_start", calc_start, 1); chk("calc_in", calc_in, ain); chk("wt_req_off", wt_req, 0);
      calc_done = g; calc_result = 8'($urandom);
      step();
      calc_done = 0;
      repeat (cd) begin
        chk("start_once", calc_start, 0); chk("in_hold", calc_in, ain);
        step();
      end
      chk("start_low", calc_start, 0);
      calc_done = 1; calc_result = res[l];
      step();
      calc_done = 0; calc_result = 8'($urandom);
      chk("act_in", calc_in, ain); chk("act_busy", busy, 1);
      step();
      ain = res[l][7] ? 8'h00 : res[l];
      lat += 4 + wd + cd;
    end
    new_data = 0; noise = 0;
    exp_out = res[n-1];
    chk("ordy", output_ready, 1); chk("done", done, 1); chk("mlp_output", mlp_output, exp_out);
    chk("latency", cyc - t0, lat);
    step();
    chk("ordy_pulse", output_ready, 0); chk("done_hold", done, 1); chk("idle", busy, 0);
    chk("start_count", n_start - s0, n); chk("ordy_count", n_ordy - o0, 1);
  endtask
  task automatic do_timeout(input bit in_compute);
    int o0;
    o0 = n_ordy;
    new_data = 1; data = 8'($urandom); cfg = 4'($urandom);
    step();
    new_data = 0;
    if (in_compute) begin
      wt_ready = 1;
      step();
      wt_ready = 0;
    end
    repeat (7) step();
    chk("to_busy", busy, 1); chk("to_err0", err, 0);
    step();
    chk("to_idle", busy, 0); chk("to_err", err, 1); chk("to_out", mlp_output, exp_out);
    chk("to_ordy", n_ordy - o0, 0); chk("to_done", done, 0);
    repeat (2) step();
    chk("err_sticky", err, 1);
  endtask
  initial begin
    repeat (2) step();
    check_all_zero();
    rst_ni = 1;
    step();
    check_all_zero();
    res[0] = 8'hF6; res[1] = 8'h83;
    do_run(8'h05, 4'd2, 0, 0);
    new_data = 1; data = 8'h11; cfg = 4'd3;
    step();
    new_data = 0; wt_ready = 1;
    step();
    wt_ready = 0;
    step();
    rst_ni = 0;
    #1;
    exp_out = '0;
    check_all_zero();
    repeat (2) step();
    chk("rst_hold", busy, 0);
    rst_ni = 1;
    for (int i = 0; i < 4; i++) res[i] = 8'($urandom);
    do_run(8'($urandom), 4'd3, 0, 0);
    for (int i = 0; i < 4; i++) res[i] = 8'($urandom);
    do_run(8'($urandom), 4'd1, 0, 1);
    do_run(8'($urandom), 4'd0, 0, 0);
    do_run(8'($urandom), 4'd7, 0, 0);
    repeat (3) step();
    chk("done_idle", done, 1);
    do_timeout(0);
    do_run(8'($urandom), 4'd2, 1, 0);
    do_timeout(1);
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 4; i++) res[i] = 8'($urandom);
      do_run(8'($urandom), 4'($urandom_range(0, 7)), 1, 0);
      repeat ($urandom_range(0, 2)) step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
